// File: rtl/motor_pkg.sv
// Types and default PWM geometry shared by the motor-control blocks
// (ramp generator, overcurrent monitor, H-bridge drive).
package motor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_HOLD  = 2'd2
    } motor_state_e;

    localparam int DUTY_W_DEF = 8;
    localparam int PERIOD_DEF = 255;

endpackage

// File: rtl/pwm_period_counter.sv
// PWM timebase: a prescaler producing ticks and a period counter running 0..PERIOD-1.
// period_start_o is registered so it is high in the first cycle that cnt_o reads 0.
module pwm_period_counter #(
    parameter int DUTY_W  = 8,
    parameter int PERIOD  = 255,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DUTY_W-1:0] cnt_o,
    output logic              tick_o,
    output logic              period_start_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              ps_q, ps_d;

    always_comb begin
        tick_o  = (presc_q == PW'(CLK_DIV - 1));
        presc_d = tick_o ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        ps_d    = 1'b0;
        if (tick_o) begin
            if (cnt_q == DUTY_W'(PERIOD - 1)) begin
                cnt_d = '0;
                ps_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + DUTY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_ramp_gen.sv
// Per-motor PWM source: accepts a target duty, slews the applied duty once per period,
// and blanks the output while the overcurrent block holds Enx low plus a holdoff.
module pwm_ramp_gen
    import motor_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int CLK_DIV   = 1,
    parameter int RAMP_STEP = 16,
    parameter int HOLDOFF   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_cmd,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              Enx,
    output logic              PWMx,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              period_start,
    output logic              faulted
);

    localparam int                HW        = $clog2(HOLDOFF + 1) + 1;
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W:0]   PER_X     = (DUTY_W + 1)'(PERIOD);
    localparam logic [DUTY_W-1:0] PER_LAST  = DUTY_W'(PERIOD - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLDOFF - 1);

    motor_state_e      state_q;
    logic [DUTY_W-1:0] cnt, duty_q, target_q, ramp_d, cmd_clamp;
    logic [DUTY_W:0]   cur_x, tgt_x, diff, over;
    logic [HW-1:0]     hold_q;
    logic              tick, wrap, xfer, ready_q, pwm_q;

    pwm_period_counter #(
        .DUTY_W (DUTY_W),
        .PERIOD (PERIOD),
        .CLK_DIV(CLK_DIV)
    ) u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .cnt_o         (cnt),
        .tick_o        (tick),
        .period_start_o(period_start)
    );

    assign wrap = tick && (cnt == PER_LAST);
    assign xfer = duty_valid && ready_q;

    // Extra bit on both sides so neither the clamp nor the slew can wrap.
    always_comb begin
        over      = PER_X - {1'b0, duty_cmd};
        cmd_clamp = over[DUTY_W] ? DUTY_W'(PERIOD) : duty_cmd;
        cur_x     = {1'b0, duty_q};
        tgt_x     = {1'b0, target_q};
        diff      = '0;
        ramp_d    = duty_q;
        if (tgt_x > cur_x) begin
            diff   = tgt_x - cur_x;
            ramp_d = (diff > STEP_X) ? DUTY_W'(cur_x + STEP_X) : target_q;
        end else if (tgt_x < cur_x) begin
            diff   = cur_x - tgt_x;
            ramp_d = (diff > STEP_X) ? DUTY_W'(cur_x - STEP_X) : target_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            duty_q   <= '0;
            target_q <= '0;
            ready_q  <= 1'b1;
            hold_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            pwm_q <= 1'b0;
            if (xfer) begin
                target_q <= cmd_clamp;
                ready_q  <= 1'b0;
            end else if (wrap) begin
                ready_q  <= 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (!Enx) begin
                        state_q <= ST_FAULT;
                        duty_q  <= '0;
                    end else begin
                        pwm_q <= (cnt < duty_q);
                        if (wrap) duty_q <= ramp_d;
                    end
                end
                ST_FAULT: begin
                    if (Enx) begin
                        state_q <= ST_HOLD;
                        hold_q  <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!Enx) begin
                        state_q <= ST_FAULT;
                        hold_q  <= '0;
                    end else if (wrap) begin
                        hold_q <= hold_q + HW'(1);
                        if (hold_q == HOLD_LAST) state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                    duty_q  <= '0;
                end
            endcase
        end
    end

    assign duty_ready = ready_q;
    assign PWMx       = pwm_q;
    assign duty_cur   = duty_q;
    assign faulted    = (state_q != ST_RUN);

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Bench for pwm_ramp_gen: per-period vector table, hand-built fault/coincidence
// sequences, a CLK_DIV=4 instance, and a randomized run against a cycle-count model.
module tb_pwm_ramp_gen;

    localparam int PERIOD = 255, RS = 16, HOLDOFF = 2;
    localparam int M_RUN = 0, M_FAULT = 1, M_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n, duty_valid, Enx, duty_ready, PWMx, period_start, faulted;
    logic [7:0] duty_cmd, duty_cur;
    logic       rst4_n, valid4, ready4, pwm4, ps4, flt4;
    logic [7:0] cmd4, duty4;

    int n_chk = 0, n_fail = 0;
    int m_cyc, m_duty, m_tgt, m_state, m_hold;
    bit m_ready, m_pwm, m_ps;

    typedef struct {bit vld; int cmd; int high; int exp;} vec_t;
    vec_t vec[$];
    int   last_exp = 0;

    always #5 clk = ~clk;

    pwm_ramp_gen #(.DUTY_W(8), .PERIOD(PERIOD), .CLK_DIV(1), .RAMP_STEP(RS), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst_n(rst_n), .duty_cmd(duty_cmd), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .Enx(Enx), .PWMx(PWMx), .duty_cur(duty_cur),
        .period_start(period_start), .faulted(faulted));

    pwm_ramp_gen #(.DUTY_W(8), .PERIOD(PERIOD), .CLK_DIV(4), .RAMP_STEP(RS), .HOLDOFF(HOLDOFF)) dut4 (
        .clk(clk), .rst_n(rst4_n), .duty_cmd(cmd4), .duty_valid(valid4),
        .duty_ready(ready4), .Enx(1'b1), .PWMx(pwm4), .duty_cur(duty4),
        .period_start(ps4), .faulted(flt4));

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ramp(int d, int t);
        if (t > d) return d + (((t - d) < RS) ? (t - d) : RS);
        return d - (((d - t) < RS) ? (d - t) : RS);
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_duty = 0; m_tgt = 0; m_state = M_RUN; m_hold = 0;
        m_ready = 1; m_pwm = 0; m_ps = 0;
    endfunction

    // Position in the period is just elapsed cycles modulo PERIOD (CLK_DIV=1).
    function automatic void model_step();
        int  pos;
        bit  bnd, xfer;
        pos  = m_cyc % PERIOD;
        bnd  = (pos == PERIOD - 1);
        xfer = duty_valid && m_ready;
        m_pwm = (m_state == M_RUN) && Enx && (pos < m_duty);
        m_ps  = bnd;
        case (m_state)
            M_RUN:   if (!Enx) begin m_state = M_FAULT; m_duty = 0; end
                     else if (bnd) m_duty = ramp(m_duty, m_tgt);
            M_FAULT: if (Enx) begin m_state = M_HOLD; m_hold = 0; end
            default: if (!Enx) begin m_state = M_FAULT; m_hold = 0; end
                     else if (bnd) begin
                         m_hold++;
                         if (m_hold == HOLDOFF) m_state = M_RUN;
                     end
        endcase
        if (xfer) begin
            m_tgt   = (int'(duty_cmd) > PERIOD) ? PERIOD : int'(duty_cmd);
            m_ready = 0;
        end else if (bnd) m_ready = 1;
        m_cyc++;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        chk("pwm", PWMx, m_pwm);
        chk("duty_cur", duty_cur, m_duty);
        chk("duty_ready", duty_ready, m_ready);
        chk("period_start", period_start, m_ps);
        chk("faulted", faulted, int'(m_state != M_RUN));
    endtask

    task automatic wait_bnd();
        int n;
        tick();
        n = 1;
        while (!period_start && n < 2 * PERIOD + 2) begin tick(); n++; end
        chk("bnd_timeout", period_start, 1);
    endtask

    function automatic void add(bit v, int c, int e);
        vec.push_back('{v, c, last_exp, e});
        last_exp = e;
    endfunction

    initial begin
        int high, n;
        rst_n = 1; rst4_n = 1; duty_valid = 0; duty_cmd = 0; Enx = 1; valid4 = 0; cmd4 = 0;

        // Each row: optional command at period start, expected duty after the next boundary,
        // expected high count in the period just finished (the previous row's duty).
        add(1, 64, 16);  add(0, 0, 32);  add(0, 0, 48);  add(0, 0, 64);  add(0, 0, 64);
        add(1, 40, 48);  add(0, 0, 40);  add(0, 0, 40);
        add(1, 255, 56);
        for (int d = 72; d <= 248; d += 16) add(0, 0, d);
        add(0, 0, 255);  add(0, 0, 255);  add(0, 0, 255);
        add(1, 0, 239);
        for (int d = 223; d >= 15; d -= 16) add(0, 0, d);
        add(0, 0, 0);    add(0, 0, 0);    add(0, 0, 0);

        #2;
        rst_n = 0; rst4_n = 0;
        model_reset();
        #1;
        chk("rst_pwm", PWMx, 0);           chk("rst_duty", duty_cur, 0);
        chk("rst_ready", duty_ready, 1);   chk("rst_ps", period_start, 0);
        chk("rst_faulted", faulted, 0);    chk("rst4_duty", duty4, 0);
        repeat (3) tick();
        rst_n = 1;

        foreach (vec[i]) begin
            duty_valid = vec[i].vld; duty_cmd = 8'(vec[i].cmd);
            high = 0;
            for (int k = 0; k < PERIOD; k++) begin
                tick();
                duty_valid = 0;
                if (k == 0 && vec[i].vld) chk("tbl_ready_drop", duty_ready, 0);
                if (PWMx) high++;
            end
            chk("tbl_high", high, vec[i].high);
            chk("tbl_duty", duty_cur, vec[i].exp);
            chk("tbl_ready_back", duty_ready, 1);
        end

        // Trip at 128, holdoff, soft restart.
        duty_valid = 1; duty_cmd = 128; tick(); duty_valid = 0;
        repeat (8) wait_bnd();
        chk("f_pre_duty", duty_cur, 128);
        repeat (100) tick();
        Enx = 0; tick();
        chk("f_pwm", PWMx, 0); chk("f_duty", duty_cur, 0); chk("f_faulted", faulted, 1);
        repeat (40) tick();
        Enx = 1; tick();
        chk("h_faulted", faulted, 1);
        wait_bnd(); chk("h1_faulted", faulted, 1); chk("h1_pwm", PWMx, 0);
        wait_bnd(); chk("h2_faulted", faulted, 0); chk("h2_duty", duty_cur, 0);
        wait_bnd(); chk("r1_duty", duty_cur, 16);
        wait_bnd(); chk("r2_duty", duty_cur, 32);

        // Enx pulse during HOLD restarts the holdoff count.
        Enx = 0; tick(); Enx = 1; tick();
        wait_bnd(); chk("hr1_faulted", faulted, 1);
        repeat (10) tick();
        Enx = 0; tick(); Enx = 1; tick();
        wait_bnd(); chk("hr2_faulted", faulted, 1);
        wait_bnd(); chk("hr3_faulted", faulted, 0);
        wait_bnd(); chk("hr4_duty", duty_cur, 16);

        // Trip coinciding with the boundary: no increment.
        repeat (PERIOD - 1) tick();
        Enx = 0; tick();
        chk("sim_trip_duty", duty_cur, 0); chk("sim_trip_faulted", faulted, 1);
        chk("sim_trip_ps", period_start, 1);
        Enx = 1; tick();
        wait_bnd(); wait_bnd();
        wait_bnd(); chk("sim_rec_duty", duty_cur, 16);

        // Transfer coinciding with the boundary: old target used there.
        repeat (PERIOD - 1) tick();
        duty_valid = 1; duty_cmd = 20; tick(); duty_valid = 0;
        chk("sim_xfer_duty", duty_cur, 32); chk("sim_xfer_ready", duty_ready, 0);
        wait_bnd();
        chk("sim_xfer_duty2", duty_cur, 20); chk("sim_xfer_ready2", duty_ready, 1);

        // CLK_DIV=4 instance: 1020-cycle periods and asynchronous reset.
        rst4_n = 1; valid4 = 1; cmd4 = 64;
        tick(); valid4 = 0; n = 1;
        while (!ps4 && n < 2100) begin tick(); n++; end
        chk("div4_first_period", n, 1020);
        chk("div4_duty1", duty4, 16);
        high = 0;
        for (int k = 0; k < 1020; k++) begin tick(); if (pwm4) high++; end
        chk("div4_high", high, 64);
        chk("div4_ps", ps4, 1);
        chk("div4_duty2", duty4, 32);
        valid4 = 1; cmd4 = 200; tick(); valid4 = 0;
        chk("div4_ready_drop", ready4, 0);
        repeat (59) tick();
        chk("div4_pwm_pre", pwm4, 1);
        rst4_n = 0;
        #1;
        chk("div4_rst_duty", duty4, 0); chk("div4_rst_ready", ready4, 1);
        chk("div4_rst_pwm", pwm4, 0);   chk("div4_rst_ps", ps4, 0);
        chk("div4_rst_faulted", flt4, 0);
        repeat (3) tick();
        rst4_n = 1; n = 0;
        while (!ps4 && n < 2100) begin tick(); n++; end
        chk("div4_restart_period", n, 1020);
        chk("div4_restart_duty", duty4, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            duty_valid = ($urandom_range(0, 5) == 0);
            duty_cmd   = 8'($urandom);
            if (Enx) Enx = ($urandom_range(0, 399) != 0);
            else     Enx = ($urandom_range(0, 29) == 0);
            tick();
        end
        Enx = 1; duty_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
